// File: rtl/gate_sweep_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// gate_sweep_ctrl_pkg : shared FSM state encoding for the gate sweep sequencer
// Rev 1.0
// ============================================================================
package gate_sweep_ctrl_pkg;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_DRIVE  = 2'd1,
      ST_SAMPLE = 2'd2,
      ST_DONE   = 2'd3
   } state_t;

endpackage
`default_nettype wire

// File: rtl/gate_sweep_ctrl_settle_timer.sv
`default_nettype none
// ============================================================================
// settle_timer : clear/enable counter; o_expired is high on the SETTLE-th
//                consecutive enabled cycle since the last clear.
// Rev 1.0
// ============================================================================
module settle_timer #(
   parameter int SETTLE = 1
) (
   input  logic clk,
   input  logic rst,
   input  logic i_clr,
   input  logic i_en,
   output logic o_expired
);

   localparam int            CW     = (SETTLE > 1) ? $clog2(SETTLE) : 1;
   localparam logic [CW-1:0] c_LAST = CW'(SETTLE - 1);
   localparam logic [CW-1:0] c_ONE  = CW'(1);

   logic [CW-1:0] r_cnt;

   always_ff @(posedge clk) begin
      if (rst || i_clr) begin
         r_cnt <= '0;
      end else if (i_en && !o_expired) begin
         r_cnt <= r_cnt + c_ONE;
      end
   end

   assign o_expired = i_en && (r_cnt == c_LAST);

endmodule
`default_nettype wire

// File: rtl/gate_sweep_ctrl.sv
`default_nettype none
// ============================================================================
// gate_sweep_ctrl : drives every input vector onto a gate under test, samples
//                   its output after a settle interval and counts mismatches.
// Optional build macro GATE_SWEEP_FIRST_FAIL_EN adds first_fail_vld/_vec.
// Rev 1.0
// ============================================================================
module gate_sweep_ctrl
   import gate_sweep_ctrl_pkg::*;
#(
   parameter int N_IN   = 2,
   parameter int SETTLE = 1,
   parameter int CNT_W  = N_IN + 1
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 start,
   input  logic [(2**N_IN)-1:0] expected_tt,
   input  logic                 gate_out,
   output logic [N_IN-1:0]      vec_out,
   output logic                 busy,
   output logic                 done,
   output logic                 pass,
   output logic [CNT_W-1:0]     err_cnt
`ifdef GATE_SWEEP_FIRST_FAIL_EN
   ,
   output logic                 first_fail_vld,
   output logic [N_IN-1:0]      first_fail_vec
`endif
);

   localparam logic [N_IN-1:0]  c_VEC_LAST = {N_IN{1'b1}};
   localparam logic [N_IN-1:0]  c_VEC_ONE  = N_IN'(1);
   localparam logic [CNT_W-1:0] c_ERR_ONE  = CNT_W'(1);

   state_t               r_state;
   state_t               w_state_nxt;
   logic [(2**N_IN)-1:0] r_tt;
   logic [N_IN-1:0]      r_vec;
   logic [CNT_W-1:0]     r_err_cnt;
   logic [CNT_W-1:0]     w_err_nxt;
   logic                 r_pass;
   logic                 w_accept;
   logic                 w_mismatch;
   logic                 w_last_vec;
   logic                 w_in_drive;
   logic                 w_settle_clr;
   logic                 w_settled;

   assign w_accept     = (r_state == ST_IDLE) && start;
   assign w_mismatch   = (gate_out != r_tt[r_vec]);
   assign w_last_vec   = (r_vec == c_VEC_LAST);
   assign w_err_nxt    = w_mismatch ? (r_err_cnt + c_ERR_ONE) : r_err_cnt;
   assign w_in_drive   = (r_state == ST_DRIVE);
   assign w_settle_clr = !w_in_drive;

   settle_timer #(
      .SETTLE (SETTLE)
   ) u_settle (
      .clk       (clk),
      .rst       (rst),
      .i_clr     (w_settle_clr),
      .i_en      (w_in_drive),
      .o_expired (w_settled)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         ST_IDLE:   if (start)     w_state_nxt = ST_DRIVE;
         ST_DRIVE:  if (w_settled) w_state_nxt = ST_SAMPLE;
         ST_SAMPLE: w_state_nxt = w_last_vec ? ST_DONE : ST_DRIVE;
         ST_DONE:   w_state_nxt = ST_IDLE;
         default:   w_state_nxt = ST_IDLE;
      endcase
   end

   // pass is resolved on the last SAMPLE so it is already valid during the done pulse
   always_ff @(posedge clk) begin
      if (rst) begin
         r_tt      <= '0;
         r_vec     <= '0;
         r_err_cnt <= '0;
         r_pass    <= 1'b0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (start) begin
                  r_tt      <= expected_tt;
                  r_vec     <= '0;
                  r_err_cnt <= '0;
                  r_pass    <= 1'b0;
               end
            end
            ST_SAMPLE: begin
               r_err_cnt <= w_err_nxt;
               if (w_last_vec) begin
                  r_pass <= (w_err_nxt == '0);
               end else begin
                  r_vec <= r_vec + c_VEC_ONE;
               end
            end
            ST_DONE: r_vec <= '0;
            default: ;
         endcase
      end
   end

   assign vec_out = r_vec;
   assign busy    = (r_state == ST_DRIVE) || (r_state == ST_SAMPLE);
   assign done    = (r_state == ST_DONE);
   assign pass    = r_pass;
   assign err_cnt = r_err_cnt;

`ifdef GATE_SWEEP_FIRST_FAIL_EN
   logic            r_ff_vld;
   logic [N_IN-1:0] r_ff_vec;

   always_ff @(posedge clk) begin
      if (rst || w_accept) begin
         r_ff_vld <= 1'b0;
         r_ff_vec <= '0;
      end else if ((r_state == ST_SAMPLE) && w_mismatch && !r_ff_vld) begin
         r_ff_vld <= 1'b1;
         r_ff_vec <= r_vec;
      end
   end

   assign first_fail_vld = r_ff_vld;
   assign first_fail_vec = r_ff_vec;
`endif

endmodule
`default_nettype wire
